// File: rtl/cdb_arbiter_if.sv
// Result-offer and CDB broadcast bundle between functional units and the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
);
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [PTR_W-1:0]          cdb_src;

    modport master (
        output flush, req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per functional unit, round-robin
// selection of one slot per cycle onto a registered broadcast.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0] slot_valid;
    logic [TAG_W-1:0]   slot_tag  [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     search_pos;

    logic               cdb_valid_reg;
    logic [TAG_W-1:0]   cdb_tag_reg;
    logic [DATA_W-1:0]  cdb_data_reg;
    logic [PTR_W-1:0]   cdb_src_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;

    // Grant looks only at held slots, so a new offer never reaches the bus in its own cycle.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        search_pos = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            search_pos = {1'b0, rr_ptr_reg} + (PTR_W+1)'(off);
            if (search_pos >= (PTR_W+1)'(NUM_REQ))
                search_pos = search_pos - (PTR_W+1)'(NUM_REQ);
            if (!grant_any && slot_valid[search_pos[PTR_W-1:0]]) begin
                grant_any                       = 1'b1;
                grant_idx                       = search_pos[PTR_W-1:0];
                grant[search_pos[PTR_W-1:0]]    = 1'b1;
            end
        end
    end

    // A slot being drained this cycle can take a new result in the same cycle.
    assign bus.req_ready = {NUM_REQ{rst & ~bus.flush}} & (~slot_valid | grant);
    assign accept        = bus.req_valid & bus.req_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            logic              valid_reg;
            logic [TAG_W-1:0]  tag_reg;
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= 1'b0;
                    tag_reg   <= '0;
                    data_reg  <= '0;
                end else if (bus.flush) begin
                    valid_reg <= 1'b0;
                end else if (accept[gi]) begin
                    valid_reg <= 1'b1;
                    tag_reg   <= bus.req_tag[gi*TAG_W +: TAG_W];
                    data_reg  <= bus.req_data[gi*DATA_W +: DATA_W];
                end else if (grant[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_tag[gi]   = tag_reg;
            assign slot_data[gi]  = data_reg;
        end
    endgenerate

    // Tag/data/src keep their last value when idle; only cdb_valid qualifies them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_data_reg  <= '0;
            cdb_src_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (bus.flush) begin
            cdb_valid_reg <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (grant_any) begin
            cdb_valid_reg <= 1'b1;
            cdb_tag_reg   <= slot_tag[grant_idx];
            cdb_data_reg  <= slot_data[grant_idx];
            cdb_src_reg   <= grant_idx;
            rr_ptr_reg    <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else begin
            cdb_valid_reg <= 1'b0;
        end
    end

    assign bus.cdb_valid = cdb_valid_reg;
    assign bus.cdb_tag   = cdb_tag_reg;
    assign bus.cdb_data  = cdb_data_reg;
    assign bus.cdb_src   = cdb_src_reg;

endmodule
